// File: rtl/tinyml_pixel_downscale_pkg.sv
// Shared widths and constants for the TinyML 2x2 downscaler: channel and
// partial-sum widths, luma coefficients and the line-buffer address width.
package tinyml_accel_pkg;

  localparam int CH_W   = 8;
  localparam int HSUM_W = 9;
  localparam int LB_W   = 27;

  localparam logic [15:0] GRAY_CR = 16'd77;
  localparam logic [15:0] GRAY_CG = 16'd150;
  localparam logic [15:0] GRAY_CB = 16'd29;

  // One line-buffer entry per output column; never narrower than one bit.
  function automatic int lb_aw(input int frame_width);
    return (frame_width / 2 > 1) ? $clog2(frame_width / 2) : 1;
  endfunction

endpackage

// File: rtl/tinyml_pixel_downscale_if.sv
// Valid-only pixel stream bundle between the DMA FIFOs and the downscaler.
// master = stream source/sink side, slave = downscaler side.
interface tinyml_pixel_downscale_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] pixel_in;
  logic                  pixel_in_valid;
  logic [DATA_WIDTH-1:0] pixel_out;
  logic                  pixel_out_valid;
  logic                  frame_done;

  modport master (
    output pixel_in, pixel_in_valid,
    input  pixel_out, pixel_out_valid, frame_done
  );

  modport slave (
    input  pixel_in, pixel_in_valid,
    output pixel_out, pixel_out_valid, frame_done
  );
endinterface

// File: rtl/tinyml_pixel_downscale_line_buffer.sv
// Simple dual-port RAM holding the even-row horizontal sums; synchronous
// one-cycle read whose data holds until the next read. No reset (block RAM).
module tinyml_line_buffer #(
  parameter int DEPTH = 320,
  parameter int AW    = 9,
  parameter int W     = 27
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/tinyml_pixel_downscale.sv
// Streaming 2x2 box-filter downscaler (RGB average, rounded). Optional luma
// output stage is enabled by defining TINYML_DOWNSCALE_GRAY_EN (adds 1 cycle).
module tinyml_pixel_downscale
  import tinyml_accel_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic                     clk,
  input  logic                     rst_n,
  tinyml_pixel_downscale_if.slave  bus
);
  localparam int LB_AW = lb_aw(FRAME_WIDTH);
  localparam int CW    = LB_AW + 1;
  localparam int RW    = (FRAME_HEIGHT > 2) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(FRAME_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);

  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [23:0]     r_hold_p0;
  logic [23:0]     w_pix;
  logic [23:0]     w_avg;
  logic [23:0]     w_out_rgb;
  logic [LB_W-1:0] w_lb_wdata;
  logic [LB_W-1:0] w_lb_rdata;
  logic            w_odd_col, w_odd_row, w_out_beat, w_last;
  logic            w_unused_hi;
  logic [23:0]     r_avg_p1;
  logic            r_vld_p1, r_done_p1;

  function automatic logic [HSUM_W-1:0] hsum(input logic [CH_W-1:0] a, input logic [CH_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Four-pixel sum plus half an LSB, then divide by four; always fits in 8 bits.
  function automatic logic [CH_W-1:0] avg_round(input logic [HSUM_W-1:0] a, input logic [HSUM_W-1:0] b);
    logic [HSUM_W:0] s;
    s = {1'b0, a} + {1'b0, b} + 10'd2;
    return s[HSUM_W:2];
  endfunction

  assign w_pix       = bus.pixel_in[23:0];
  assign w_unused_hi = ^bus.pixel_in[DATA_WIDTH-1:24];
  assign w_odd_col   = r_col[0];
  assign w_odd_row   = r_row[0];
  assign w_out_beat  = bus.pixel_in_valid & w_odd_col & w_odd_row;
  assign w_last      = (r_col == COL_LAST) && (r_row == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_hold_p0 <= '0;
    end else if (bus.pixel_in_valid) begin
      if (!w_odd_col) r_hold_p0 <= w_pix;
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_comb begin
    w_lb_wdata = '0;
    w_avg      = '0;
    for (int ch = 0; ch < 3; ch++) begin
      w_lb_wdata[ch*HSUM_W +: HSUM_W] = hsum(r_hold_p0[ch*CH_W +: CH_W], w_pix[ch*CH_W +: CH_W]);
      w_avg[ch*CH_W +: CH_W] = avg_round(w_lb_rdata[ch*HSUM_W +: HSUM_W],
                                         w_lb_wdata[ch*HSUM_W +: HSUM_W]);
    end
  end

  // Read is launched on the even beat of an odd row so it lands for the odd beat.
  tinyml_line_buffer #(
    .DEPTH (FRAME_WIDTH / 2),
    .AW    (LB_AW),
    .W     (LB_W)
  ) u_lb (
    .clk     (clk),
    .i_we    (bus.pixel_in_valid & w_odd_col & ~w_odd_row),
    .i_waddr (r_col[CW-1:1]),
    .i_wdata (w_lb_wdata),
    .i_re    (bus.pixel_in_valid & ~w_odd_col & w_odd_row),
    .i_raddr (r_col[CW-1:1]),
    .o_rdata (w_lb_rdata)
  );

  // ---- stage p0 -> p1: averaged pixel ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_avg_p1  <= '0;
      r_vld_p1  <= 1'b0;
      r_done_p1 <= 1'b0;
    end else begin
      r_vld_p1  <= w_out_beat;
      r_done_p1 <= w_out_beat & w_last;
      if (w_out_beat) r_avg_p1 <= w_avg;
    end
  end

`ifdef TINYML_DOWNSCALE_GRAY_EN
  logic [CH_W-1:0] r_y_p2;
  logic            r_vld_p2, r_done_p2;

  function automatic logic [CH_W-1:0] luma(input logic [23:0] rgb);
    logic [15:0] acc;
    acc = {8'h00, rgb[23:16]} * GRAY_CR + {8'h00, rgb[15:8]} * GRAY_CG
        + {8'h00, rgb[7:0]} * GRAY_CB + 16'd128;
    return acc[15:8];
  endfunction

  // ---- stage p1 -> p2: luma ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_p2    <= '0;
      r_vld_p2  <= 1'b0;
      r_done_p2 <= 1'b0;
    end else begin
      r_vld_p2  <= r_vld_p1;
      r_done_p2 <= r_done_p1;
      if (r_vld_p1) r_y_p2 <= luma(r_avg_p1);
    end
  end

  assign w_out_rgb           = {r_y_p2, r_y_p2, r_y_p2};
  assign bus.pixel_out_valid = r_vld_p2;
  assign bus.frame_done      = r_done_p2;
`else
  assign w_out_rgb           = r_avg_p1;
  assign bus.pixel_out_valid = r_vld_p1;
  assign bus.frame_done      = r_done_p1;
`endif

  assign bus.pixel_out = {{(DATA_WIDTH-24){1'b0}}, w_out_rgb};
endmodule

// File: tb/tb_tinyml_pixel_downscale.sv
// Bench for the 2x2 downscaler: a 4x2 and a 6x4 instance, a frame-level
// expectation model and a per-cycle output comparator.
module tb_tinyml_pixel_downscale;
  localparam int FWA = 4, FHA = 2, FWB = 6, FHB = 4;
`ifdef TINYML_DOWNSCALE_GRAY_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] pix;
    logic        done;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tinyml_pixel_downscale_if #(.DATA_WIDTH(32)) ia ();
  tinyml_pixel_downscale_if #(.DATA_WIDTH(32)) ib ();

  tinyml_pixel_downscale #(.DATA_WIDTH(32), .FRAME_WIDTH(FWA), .FRAME_HEIGHT(FHA)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave));
  tinyml_pixel_downscale #(.DATA_WIDTH(32), .FRAME_WIDTH(FWB), .FRAME_HEIGHT(FHB)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave));

  int checks = 0, errors = 0;
  exp_t q0[$], q1[$];
  logic [31:0] loga[$], logb[$];
  logic [23:0] img [2][FHB][FWB];
  int mcol[2], mrow[2];
  logic [31:0] hold[2];
  int ndone[2], ndone_exp[2];
  logic [31:0] f1[8], f2[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Box average of the four pixels, optionally converted to luma.
  function automatic logic [31:0] model_px(input logic [23:0] a, input logic [23:0] b,
                                           input logic [23:0] c, input logic [23:0] d);
    int ch[3];
    int y;
    for (int k = 0; k < 3; k++)
      ch[k] = (int'(a[k*8 +: 8]) + int'(b[k*8 +: 8]) + int'(c[k*8 +: 8]) + int'(d[k*8 +: 8]) + 2) / 4;
    y = (77 * ch[2] + 150 * ch[1] + 29 * ch[0] + 128) / 256;
`ifdef TINYML_DOWNSCALE_GRAY_EN
    return {8'h00, 8'(y), 8'(y), 8'(y)};
`else
    return {8'h00, 8'(ch[2]), 8'(ch[1]), 8'(ch[0])};
`endif
  endfunction

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpop(input int u, output exp_t e);
    if (u == 0) e = q0.pop_front();
    else        e = q1.pop_front();
  endtask

  task automatic cmp(input int u, input logic [31:0] pix, input logic vld, input logic done);
    exp_t e;
    string n;
    n = (u == 0) ? "a" : "b";
    if (done) ndone[u]++;
    if (vld) begin
      if (u == 0) loga.push_back(pix); else logb.push_back(pix);
      if (qsize(u) == 0) begin
        chk({n, "_unexpected_valid"}, {31'b0, vld}, 32'd0);
      end else begin
        qpop(u, e);
        chk({n, "_pixel"}, pix, e.pix);
        chk({n, "_frame_done"}, {31'b0, done}, {31'b0, e.done});
        chk({n, "_latency_cycle"}, cyc, e.cyc);
        hold[u] = e.pix;
      end
    end else begin
      chk({n, "_done_without_valid"}, {31'b0, done}, 32'd0);
      chk({n, "_pixel_hold"}, pix, hold[u]);
      if (qsize(u) > 0) begin
        e = (u == 0) ? q0[0] : q1[0];
        if (e.cyc <= cyc) begin
          chk({n, "_missing_valid"}, {31'b0, vld}, 32'd1);
          qpop(u, e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    cmp(0, ia.pixel_out, ia.pixel_out_valid, ia.frame_done);
    cmp(1, ib.pixel_out, ib.pixel_out_valid, ib.frame_done);
  end

  task automatic drive(input int u, input logic [31:0] p, input logic v);
    if (u == 0) begin ia.pixel_in = p; ia.pixel_in_valid = v; end
    else        begin ib.pixel_in = p; ib.pixel_in_valid = v; end
  endtask

  task automatic accept(input int u, input logic [31:0] p);
    int c, r, w, h;
    exp_t e;
    c = mcol[u]; r = mrow[u];
    w = (u == 0) ? FWA : FWB;
    h = (u == 0) ? FHA : FHB;
    img[u][r][c] = p[23:0];
    if ((c % 2 == 1) && (r % 2 == 1)) begin
      e.pix  = model_px(img[u][r-1][c-1], img[u][r-1][c], img[u][r][c-1], img[u][r][c]);
      e.done = (c == w - 1) && (r == h - 1);
      e.cyc  = cyc + LAT;
      if (e.done) ndone_exp[u]++;
      if (u == 0) q0.push_back(e); else q1.push_back(e);
    end
    c++;
    if (c == w) begin
      c = 0;
      r = (r == h - 1) ? 0 : r + 1;
    end
    mcol[u] = c; mrow[u] = r;
  endtask

  task automatic send(input int u, input logic [31:0] p, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      drive(u, $urandom, 1'b0);
    end
    @(negedge clk);
    drive(u, p, 1'b1);
    accept(u, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(0, $urandom, 1'b0);
      drive(1, $urandom, 1'b0);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    foreach (q0[i]) if (q0[i].done) ndone_exp[0]--;
    foreach (q1[i]) if (q1[i].done) ndone_exp[1]--;
    q0.delete(); q1.delete();
    mcol = '{0, 0}; mrow = '{0, 0};
    hold[0] = '0; hold[1] = '0;
    idle(2);
    chk("a_reset_pixel_out", ia.pixel_out, 32'd0);
    chk("a_reset_valid", {31'b0, ia.pixel_out_valid}, 32'd0);
    chk("a_reset_frame_done", {31'b0, ia.frame_done}, 32'd0);
    chk("b_reset_pixel_out", ib.pixel_out, 32'd0);
    chk("b_reset_valid", {31'b0, ib.pixel_out_valid}, 32'd0);
    chk("b_reset_frame_done", {31'b0, ib.frame_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic end_test(input string name);
    idle(LAT + 3);
    chk({name, "_pending_outputs"}, 32'(q0.size() + q1.size()), 32'd0);
    chk({name, "_a_done_count"}, 32'(ndone[0]), 32'(ndone_exp[0]));
    chk({name, "_b_done_count"}, 32'(ndone[1]), 32'(ndone_exp[1]));
  endtask

  initial begin
    int base;
    ndone = '{0, 0}; ndone_exp = '{0, 0};
    hold[0] = '0; hold[1] = '0;
    f1 = '{32'h000A0000, 32'hAB140000, 32'h001E0000, 32'h00280000,
           32'h00320000, 32'h003C0000, 32'h7F460000, 32'h00510000};
    f2 = '{32'h00010203, 32'h00FF8040, 32'h00102030, 32'h00405060,
           32'h0011EE22, 32'h00C0FF00, 32'h00070809, 32'h00FFFFFF};
    drive(0, 32'd0, 1'b0);
    drive(1, 32'd0, 1'b0);
    do_reset();

`ifndef TINYML_DOWNSCALE_GRAY_EN
    chk("model_pin_r35", model_px(24'h0A0000, 24'h140000, 24'h320000, 24'h3C0000), 32'h00230000);
    chk("model_pin_r55", model_px(24'h1E0000, 24'h280000, 24'h460000, 24'h510000), 32'h00370000);
`endif

    // Directed 4x2 frame, no gaps
    loga.delete();
    for (int i = 0; i < 8; i++) send(0, f1[i], 0);
    end_test("t1");
    chk("t1_out_count", 32'(loga.size()), 32'd2);
`ifndef TINYML_DOWNSCALE_GRAY_EN
    if (loga.size() == 2) begin
      chk("t1_out0_literal", loga[0], 32'h00230000);
      chk("t1_out1_literal", loga[1], 32'h00370000);
    end
`endif

    // Same frame with random gaps
    for (int i = 0; i < 8; i++) send(0, f1[i], $urandom_range(0, 3));
    end_test("t2");

    // Two back-to-back frames with different data
    for (int i = 0; i < 8; i++) send(0, f1[i], 0);
    for (int i = 0; i < 8; i++) send(0, f2[i], 0);
    end_test("t3");

`ifdef TINYML_DOWNSCALE_GRAY_EN
    loga.delete();
    for (int i = 0; i < 8; i++) send(0, 32'h00646464, 0);
    for (int i = 0; i < 8; i++) send(0, 32'h00FF0000, 0);
    end_test("gray");
    chk("gray_out_count", 32'(loga.size()), 32'd4);
    if (loga.size() == 4) begin
      chk("gray_uniform100", loga[0], 32'h00646464);
      chk("gray_red255", loga[3], 32'h004D4D4D);
    end
`endif

    // 6x4 frame saturated at all ones
    logb.delete();
    for (int i = 0; i < FWB * FHB; i++) send(1, 32'hFFFFFFFF, 0);
    end_test("t4");
    chk("t4_out_count", 32'(logb.size()), 32'd6);
    if (logb.size() == 6) chk("t4_last_literal", logb[5], 32'h00FFFFFF);

    // 6x4 random frames with gaps
    for (int i = 0; i < 2 * FWB * FHB; i++) send(1, $urandom, $urandom_range(0, 2));
    end_test("t5");

    // Reset after 5 pixels, then a clean frame
    for (int i = 0; i < 5; i++) send(0, f1[i], 0);
    do_reset();
    for (int i = 0; i < 8; i++) send(0, f2[i], 0);
    end_test("t6");

    // Reset while the last output of a frame is in flight
    base = loga.size();
    for (int i = 0; i < 8; i++) send(0, f1[i], 0);
    do_reset();
    end_test("t7");
    chk("t7_dropped_output", 32'(loga.size() - base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tinyml_pixel_downscale.md
# tinyml_pixel_downscale

Streaming 2x2 box-filter downscaler for the TinyML vision path. It takes the RGB pixel stream that the DMA input FIFO delivers (one 32-bit word per pixel, raster order) and emits a half-width, half-height stream to the DMA output FIFO, in place of the accelerator core. It is valid-only: no backpressure; the wrapper throttles the input so the output FIFO never overflows.

## Interface
- DATA_WIDTH, 32: pixel word width; only bits [23:0] = {R,G,B} are meaningful.
- FRAME_WIDTH, 640: input pixels per line; must be even, ≥2.
- FRAME_HEIGHT, 480: input lines per frame; must be even, ≥2.
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- pixel_in  in  DATA_WIDTH  input pixel; [31:24] ignored.
- pixel_in_valid  in  1  pixel_in accepted this cycle.
- pixel_out  out  DATA_WIDTH  {8'h00, R, G, B} averaged pixel.
- pixel_out_valid  out  1  one-cycle strobe per output pixel.
- frame_done  out  1  one-cycle pulse coincident with the last output pixel of a frame.

## Operation
- Counters col (0..FRAME_WIDTH-1) and row (0..FRAME_HEIGHT-1) advance only on pixel_in_valid. col wraps to 0 and row increments at col = FRAME_WIDTH-1. Both wrap to 0 after (FRAME_WIDTH-1, FRAME_HEIGHT-1); the next frame starts with no idle cycle required.
- Even col: register the pixel (hold_r).
- Odd col: per channel, hsum = hold_r + pixel (9 bits).
  - Even row: write the three 9-bit hsums (27 bits) to the line buffer at address col>>1.
  - Odd row: out = (lb_rdata + hsum + 2) >> 2 per channel; 10-bit intermediate; the result is ≤255, so no saturation logic.
- The line-buffer read for address col>>1 is issued on the even-col beat of odd rows, so data is ready at the odd beat. Arbitrary gaps in pixel_in_valid are allowed: the read data and hold_r stay stable until the next valid.
- Output order is raster at FRAME_WIDTH/2 x FRAME_HEIGHT/2. There are no outputs during even rows.

## Timing
- Reset values: pixel_out = 0, pixel_out_valid = 0, frame_done = 0, col = row = 0, hold_r = 0.
- Latency: pixel_out_valid asserts 1 cycle after the accepted (odd col, odd row) input. With the grayscale option enabled, latency is 2 cycles.
- pixel_out holds its value between strobes.
- frame_done asserts on the same cycle as the pixel_out_valid for input pixel (FRAME_WIDTH-1, FRAME_HEIGHT-1).
- Reset mid-frame:
  - counters and pipeline clear;
  - any in-flight output is dropped, with no pixel_out_valid afterwards;
  - line buffer contents are don't-care, because row 0 rewrites them.
- Throughput: 1 input pixel per cycle sustained.

## Configuration
- TINYML_DOWNSCALE_GRAY_EN defined:
  - after averaging, Y = (77R + 150G + 29B + 128) >> 8 (16-bit intermediate);
  - pixel_out = {8'h00, Y, Y, Y};
  - one extra register stage is added, so latency is 2.
- Undefined: RGB average output with latency 1. The multiplier logic is absent.

## Structure
- Package tinyml_accel_pkg:
  - CH_W = 8, HSUM_W = 9, LB_W = 27;
  - gray coefficients 77/150/29;
  - function clog2-based LB_AW = $clog2(FRAME_WIDTH/2).
- Sub-module tinyml_line_buffer: simple dual-port RAM, FRAME_WIDTH/2 x 27 bits, synchronous 1-cycle read, no reset, inferred as block RAM.

## Test plan
- FRAME 4x2, R channel inputs row0 = 10, 20, 30, 40 and row1 = 50, 60, 70, 81, G = B = 0 -> two outputs R = 35 then 55 (0x00230000, 0x00370000); frame_done on the second.
- Same frame with random 0–3 cycle gaps between pixel_in_valid -> identical outputs, each 1 cycle after the odd/odd input.
- All inputs 0xFFFFFFFF, 640x480 -> 76,800 outputs of 0x00FFFFFF; exactly one frame_done.
- Two back-to-back 4x2 frames with different data -> 4 outputs, correct per frame, two frame_done pulses.
- Deassert rst_n after 5 pixels of frame 1, then feed a clean frame -> no outputs from the partial frame; the clean frame matches the golden model.
- TINYML_DOWNSCALE_GRAY_EN, uniform R = G = B = 100 -> pixel_out = 0x00646464 at 2-cycle latency; R = 255, G = B = 0 -> Y = 77 (0x004D4D4D).
